// File: rtl/weight_mem_ctrl_pkg.sv
// rtl/weight_mem_ctrl_pkg.sv - shared types and constants for the weight memory sequencer
package weight_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int WEIGHT_NUM_DEF = 8010;
  localparam int WORDS_PER_ROW  = 3;
  localparam int WORD_W         = 16;
  localparam int ROW_W          = WORDS_PER_ROW * WORD_W;

  // Words spanned by rows [0, base+count): 3*(base+count) without overflow.
  // Arguments are zero-extended by the caller so the sum and the x3 both fit.
  function automatic logic [18:0] row_span_words(input logic [18:0] base, input logic [18:0] count);
    logic [18:0] sum;
    sum = base + count;
    return sum + {sum[17:0], 1'b0};
  endfunction

endpackage

// File: rtl/weight_row_outreg.sv
// rtl/weight_row_outreg.sv - one-entry valid/ready register holding the row presented to the consumer
module weight_row_outreg
  import weight_mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ROW_W-1:0] load_data,
  input  logic             row_ready,
  output logic             row_valid,
  output logic [ROW_W-1:0] row_data,
  output logic             can_load,
  output logic             taken
);

  // A new row may enter when the slot is empty or its occupant leaves this cycle.
  assign taken    = row_valid && row_ready;
  assign can_load = !row_valid || row_ready;

  // Load has priority so drain-and-reload keeps the slot full back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_valid <= 1'b0;
      row_data  <= '0;
    end else if (load) begin
      row_valid <= 1'b1;
      row_data  <= load_data;
    end else if (taken) begin
      row_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/weight_mem_ctrl.sv
// rtl/weight_mem_ctrl.sv - weight memory load/replay sequencer (optional WEIGHT_MEM_CTRL_RANGE_CHECK_EN)
module weight_mem_ctrl
  import weight_mem_ctrl_pkg::*;
#(
  parameter int WEIGHT_NUM = WEIGHT_NUM_DEF,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_count,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              load_done,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] fetch_row_base,
  input  logic [ADDR_W-1:0] fetch_row_count,
  output logic              row_valid,
  output logic [ROW_W-1:0]  row_data,
  input  logic              row_ready,
  output logic              fetch_done,
  output logic              busy,
  output logic              err,
  output logic              write_weight_signal,
  output logic [WORD_W-1:0] write_weight_data,
  output logic              read_weight_signal,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [ROW_W-1:0]  read_weight_data
);

  state_t state, state_nxt;

  // Counters carry one extra bit so a full-range count never wraps to zero.
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   ld_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   f_cnt;
  logic [ADDR_W-1:0] f_base;
  logic [ADDR_W:0]   rd_row;

  logic load_go;
  logic fetch_go;
  logic load_bad;
  logic fetch_bad;
  logic wr_acc;
  logic last_wr;
  logic rd_issue;
  logic last_issue;
  logic row_space;
  logic row_taken;

`ifdef WEIGHT_MEM_CTRL_RANGE_CHECK_EN
  localparam logic [18:0] WEIGHT_NUM_W = 19'(WEIGHT_NUM);

  logic [18:0] fetch_span;
  logic        start_rej;
  logic        err_q;

  assign fetch_span = row_span_words(19'(fetch_row_base), 19'(fetch_row_count));
  assign load_bad   = (load_count == '0) || (19'(load_count) > WEIGHT_NUM_W);
  assign fetch_bad  = (fetch_row_count == '0) || (fetch_span > WEIGHT_NUM_W);

  // A start seen in IDLE that fails its range test; load wins over fetch here too.
  assign start_rej  = (state == ST_IDLE) &&
                      (load_start ? load_bad : (fetch_start && fetch_bad));

  // Sticky error: set by a rejected start, cleared by the next accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_rej) begin
      err_q <= 1'b1;
    end else if (load_go || fetch_go) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign load_bad  = 1'b0;
  assign fetch_bad = 1'b0;
  assign err       = 1'b0;
`endif

  assign last_wr    = (wr_cnt + 1'b1) == ld_cnt;
  assign last_issue = (rd_cnt + 1'b1) == f_cnt;
  assign rd_row     = {1'b0, f_base} + rd_cnt;

  // Next state and start decode; busy starts ignored by only looking in IDLE.
  always_comb begin
    state_nxt = state;
    load_go   = 1'b0;
    fetch_go  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          if (!load_bad) begin
            load_go   = 1'b1;
            state_nxt = ST_LOAD;
          end
        end else if (fetch_start) begin
          if (!fetch_bad) begin
            fetch_go  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_LOAD: begin
        if (wr_acc && last_wr) state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        if (rd_issue && last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (row_taken) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory port drive: write on accepted words, read on issue cycles, address idle at zero.
  always_comb begin
    in_ready            = (state == ST_LOAD);
    wr_acc              = in_ready && in_valid;
    rd_issue            = (state == ST_FETCH) && row_space;
    write_weight_signal = wr_acc;
    write_weight_data   = '0;
    read_weight_signal  = rd_issue;
    weight_addr         = '0;
    busy                = (state != ST_IDLE);
    if (wr_acc) begin
      write_weight_data = in_data;
      weight_addr       = wr_cnt[ADDR_W-1:0];
    end else if (rd_issue) begin
      weight_addr       = rd_row[ADDR_W-1:0];
    end
  end

  // State register and the one-cycle done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      load_done  <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      load_done  <= (state == ST_LOAD) && wr_acc && last_wr;
      fetch_done <= (state == ST_DRAIN) && row_taken;
    end
  end

  // Load word counter, armed with the requested length on an accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      ld_cnt <= '0;
    end else if (load_go) begin
      wr_cnt <= '0;
      ld_cnt <= {1'b0, load_count};
    end else if (wr_acc) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // Replay row counter, armed with base and length on an accepted fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      f_cnt  <= '0;
      f_base <= '0;
    end else if (fetch_go) begin
      rd_cnt <= '0;
      f_cnt  <= {1'b0, fetch_row_count};
      f_base <= fetch_row_base;
    end else if (rd_issue) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  weight_row_outreg u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (rd_issue),
    .load_data (read_weight_data),
    .row_ready (row_ready),
    .row_valid (row_valid),
    .row_data  (row_data),
    .can_load  (row_space),
    .taken     (row_taken)
  );

endmodule

// File: doc/weight_mem_ctrl.md
# weight_mem_ctrl

Sequencer for the layer's local weight memory. It loads a weight stream from the bus-side loader into the memory one 16-bit word per cycle. It then replays contiguous ranges of 48-bit kernel rows (three weights per row) to the convolution engine under valid/ready flow control. It is the only master of the weight memory's read/write/address ports.

## Interface
Parameters:
- WEIGHT_NUM, 8010: memory depth in 16-bit words.
- ADDR_W, 16: width of all address/count fields.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle request to begin a load.
- load_count  in  16  number of words to load (1..WEIGHT_NUM); sampled with load_start.
- in_valid  in  1  stream word valid.
- in_data  in  16  stream word.
- in_ready  out  1  word accepted when in_valid && in_ready.
- load_done  out  1  one-cycle pulse after the last word is written.
- fetch_start  in  1  one-cycle request to begin a row replay.
- fetch_row_base  in  16  first row index; sampled with fetch_start.
- fetch_row_count  in  16  rows to replay (≥1); sampled with fetch_start.
- row_valid  out  1  row_data holds a row.
- row_data  out  48  [15:0]=word 3r, [31:16]=3r+1, [47:32]=3r+2.
- row_ready  in  1  consumer accepts row on row_valid && row_ready.
- fetch_done  out  1  one-cycle pulse when the last row is accepted.
- busy  out  1  state != IDLE.
- err  out  1  sticky range-error flag; cleared by rst or the next accepted start.
- write_weight_signal  out  1  memory write enable.
- write_weight_data  out  16  memory write data.
- read_weight_signal  out  1  memory read enable.
- weight_addr  out  16  word address when writing, row index when reading.
- read_weight_data  in  48  combinational memory read data.

## Operation
- States: IDLE, LOAD, FETCH, DRAIN.
- IDLE: in_ready=0, all memory enables 0.
  - load_start has priority over a simultaneous fetch_start.
  - Starts arriving while busy are ignored.
- LOAD:
  - in_ready=1.
  - Each accepted word: write_weight_signal=1, weight_addr=wr_cnt, write_weight_data=in_data, wr_cnt++.
  - After word load_count-1 is accepted: load_done pulses the next cycle; state goes to IDLE.
- FETCH:
  - Read issued when the output register is empty or is being drained this cycle: read_weight_signal=1, weight_addr=base+rd_cnt.
  - read_weight_data is captured into row_data at the same edge; rd_cnt++.
  - After the last issue: state goes to DRAIN.
- DRAIN:
  - Waits for the last row handshake.
  - fetch_done pulses the cycle after acceptance; state goes to IDLE.
- Arithmetic: range sums computed at 17/18 bits; no wrap of wr_cnt or rd_cnt.
- Outside LOAD: write_weight_signal=0. Outside issue cycles: read_weight_signal=0 and weight_addr=0.
- No internal memory-clear; memory contents persist across IDLE.

## Timing
- Reset values: in_ready, row_valid, row_data, load_done, fetch_done, busy, err, both memory enables, weight_addr, write_weight_data all 0; state IDLE.
- LOAD: one word per cycle at full stream rate; in_valid gaps stall without side effect.
- FETCH: first row_valid 2 cycles after fetch_start (1 cycle state entry, 1 cycle issue/capture). Sustained rate is 1 row/cycle with row_ready held high.
- row_valid low with row_ready: no effect. row_data stays stable while row_valid && !row_ready.
- rst mid-LOAD or mid-FETCH: immediate return to IDLE. Any partial row is discarded; already-written words remain.
- busy rises the cycle after an accepted start and falls the same cycle the done pulse is asserted.

## Configuration
- WEIGHT_MEM_CTRL_RANGE_CHECK_EN defined:
  - load_start with load_count=0 or >WEIGHT_NUM is rejected.
  - fetch_start with fetch_row_count=0 or 3*(base+count)>WEIGHT_NUM is rejected.
  - On rejection: err=1, state stays IDLE, no memory access.
- Undefined: no checks; err tied to 0; out-of-range requests are executed as issued.

## Structure
- Package weight_mem_ctrl_pkg: state enum, WEIGHT_NUM_DEF=8010, WORDS_PER_ROW=3, ROW_W=48.
- Sub-module weight_row_outreg: one-entry valid/ready output register (load, hold, drain-and-reload same cycle).

## Test plan
- Load 9 words 0x0001..0x0009 at full rate: 9 write cycles at addr 0..8, load_done pulses once, busy then 0.
- Fetch base=1, count=2, row_ready=1: row_data 0x000600050004 then 0x000900080007 on consecutive cycles; fetch_done one pulse.
- Same fetch with row_ready toggling 1,0,0,1: each row held stable while stalled; exactly 2 handshakes; no duplicate read issued.
- load_start and fetch_start in the same cycle: LOAD entered, fetch ignored; fetch_start during LOAD is ignored.
- With the macro defined, fetch base=2670, count=1 on WEIGHT_NUM=8010: err=1, busy stays 0, read_weight_signal never asserted.
- rst asserted on the 3rd word of a 9-word load: all outputs 0 next cycle, state IDLE; words 0..1 remain readable afterward.
